// File: rtl/onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for the dual-port on-chip RAM.
// One instance per port; the RAM takes the slave view, a bus master the master view.
interface onchip_memory_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_memory_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slaves on one clock.
// Byte-lane writes, 1- or 2-cycle read latency with readdatavalid, s1-wins write
// collision arbitration (s2 stalled one cycle) and out-of-range protection.
// Memory contents are never touched by reset. INIT_FILE is attached to the RAM
// by the device memory-initialisation flow, not by this RTL.
module onchip_memory_dp #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 16,
    parameter int    DEPTH        = 51200,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_memory_dp.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    onchip_memory_dp_if.slave s1,
    onchip_memory_dp_if.slave s2
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [IDX_W-1:0]      w_idx   [2];
    logic [BE_W-1:0]       w_be    [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];
    logic [DATA_WIDTH-1:0] w_rdata [2];
    logic [1:0]            w_cs;
    logic [1:0]            w_rd_req;
    logic [1:0]            w_wr_req;
    logic [1:0]            w_inr;
    logic [1:0]            w_wait;
    logic [1:0]            w_wr_acc;
    logic [1:0]            w_rd_acc;
    logic [1:0]            w_rvalid;
    logic                  w_collide;

    assign w_addr[0]   = s1.address;
    assign w_addr[1]   = s2.address;
    assign w_be[0]     = s1.byteenable;
    assign w_be[1]     = s2.byteenable;
    assign w_wdata[0]  = s1.writedata;
    assign w_wdata[1]  = s2.writedata;
    assign w_cs        = {s2.chipselect, s1.chipselect};
    assign w_rd_req    = {s2.read, s1.read};
    assign w_wr_req    = {s2.write, s1.write};

    // Both ports writing the same valid word: s1 wins, s2 retries next cycle.
    assign w_collide = w_cs[0] & w_wr_req[0] & w_cs[1] & w_wr_req[1]
                     & (w_addr[0] == w_addr[1]) & w_inr[0];

    assign w_wait[0] = reset | ~clken;
    assign w_wait[1] = reset | ~clken | w_collide;

    assign s1.waitrequest   = w_wait[0];
    assign s2.waitrequest   = w_wait[1];
    assign s1.readdata      = w_rdata[0];
    assign s2.readdata      = w_rdata[1];
    assign s1.readdatavalid = w_rvalid[0];
    assign s2.readdatavalid = w_rvalid[1];

    // Byte-lane writes from both ports; collision stall guarantees distinct addresses.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_wr_acc[p] && w_inr[p]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (w_be[p][b]) begin
                        r_mem[w_idx[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar gp = 0; gp < 2; gp++) begin : g_port
        logic                  r_p1_vld;
        logic [DATA_WIDTH-1:0] r_p1_data;

        assign w_idx[gp]    = w_addr[gp][IDX_W-1:0];
        assign w_inr[gp]    = ({1'b0, w_addr[gp]} < DEPTH_L);
        assign w_wr_acc[gp] = w_cs[gp] & w_wr_req[gp] & ~w_wait[gp];
        // read+write together is treated as a write only
        assign w_rd_acc[gp] = w_cs[gp] & w_rd_req[gp] & ~w_wr_req[gp] & ~w_wait[gp];

        // First read stage: array read at acceptance (old data on a same-edge write
        // from the other port), zero for out-of-range, held while no new read.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_p1_vld  <= 1'b0;
                r_p1_data <= '0;
            end else if (clken) begin
                r_p1_vld <= w_rd_acc[gp];
                if (w_rd_acc[gp]) begin
                    r_p1_data <= w_inr[gp] ? r_mem[w_idx[gp]] : '0;
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_p2_vld;
            logic [DATA_WIDTH-1:0] r_p2_data;

            // Output register stage; data only moves with a valid beat so it holds otherwise.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_p2_vld  <= 1'b0;
                    r_p2_data <= '0;
                end else if (clken) begin
                    r_p2_vld <= r_p1_vld;
                    if (r_p1_vld) begin
                        r_p2_data <= r_p1_data;
                    end
                end
            end

            assign w_rvalid[gp] = r_p2_vld;
            assign w_rdata[gp]  = r_p2_data;
        end else begin : g_lat1
            assign w_rvalid[gp] = r_p1_vld;
            assign w_rdata[gp]  = r_p1_data;
        end
    end

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed bench for onchip_memory_dp: one READ_LATENCY=2 instance (a*) carries
// most scenarios, a READ_LATENCY=1 instance (b*) covers the short-latency path.
module tb_onchip_memory_dp;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int DEP = 64;

    logic clk = 1'b0;
    logic reset;
    logic clken;
    int   n_pass;
    int   n_total;

    always #5 clk = ~clk;

    onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
    onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2 ();
    onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
    onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

    onchip_memory_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(2), .INIT_FILE("")
    ) u_dut_l2 (
        .clk(clk), .reset(reset), .clken(clken), .s1(a1), .s2(a2)
    );

    onchip_memory_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(1), .INIT_FILE("")
    ) u_dut_l1 (
        .clk(clk), .reset(reset), .clken(clken), .s1(b1), .s2(b2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a1_cmd(input logic rd, input logic wr, input logic [7:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
        a1.chipselect = rd | wr; a1.read = rd; a1.write = wr;
        a1.address = ad; a1.byteenable = be; a1.writedata = wd;
    endtask

    task automatic a2_cmd(input logic rd, input logic wr, input logic [7:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
        a2.chipselect = rd | wr; a2.read = rd; a2.write = wr;
        a2.address = ad; a2.byteenable = be; a2.writedata = wd;
    endtask

    task automatic b1_cmd(input logic rd, input logic wr, input logic [7:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
        b1.chipselect = rd | wr; b1.read = rd; b1.write = wr;
        b1.address = ad; b1.byteenable = be; b1.writedata = wd;
    endtask

    task automatic b2_cmd(input logic rd, input logic wr, input logic [7:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
        b2.chipselect = rd | wr; b2.read = rd; b2.write = wr;
        b2.address = ad; b2.byteenable = be; b2.writedata = wd;
    endtask

    task automatic idle_all();
        a1_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        a2_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        b1_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        b2_cmd(0, 0, 8'd0, 4'h0, 32'h0);
    endtask

    // latency-2 read: accept at edge E, valid right after E+1
    task automatic rd_a1_chk(input logic [7:0] ad, input logic [31:0] exp, input string tag);
        a1_cmd(1, 0, ad, 4'h0, 32'h0);
        tick();
        a1_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        tick();
        chk({tag, "_vld"}, {31'd0, a1.readdatavalid}, 32'd1);
        chk(tag, a1.readdata, exp);
    endtask

    task automatic rd_a2_chk(input logic [7:0] ad, input logic [31:0] exp, input string tag);
        a2_cmd(1, 0, ad, 4'h0, 32'h0);
        tick();
        a2_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        tick();
        chk({tag, "_vld"}, {31'd0, a2.readdatavalid}, 32'd1);
        chk(tag, a2.readdata, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        clken   = 1'b1;
        idle_all();
        tick();
        tick();

        // reset state
        chk("rst_a1_wait", {31'd0, a1.waitrequest}, 32'd1);
        chk("rst_a2_wait", {31'd0, a2.waitrequest}, 32'd1);
        chk("rst_a1_vld", {31'd0, a1.readdatavalid}, 32'd0);
        chk("rst_a2_data", a2.readdata, 32'h0);
        chk("rst_b1_data", b1.readdata, 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_a1_wait", {31'd0, a1.waitrequest}, 32'd0);
        chk("rel_a2_wait", {31'd0, a2.waitrequest}, 32'd0);
        tick();

        // latency-1 instance: write, same-port read next cycle, out-of-range read on s2
        b1_cmd(0, 1, 8'd3, 4'hF, 32'hCAFEF00D);
        tick();
        b1_cmd(1, 0, 8'd3, 4'h0, 32'h0);
        b2_cmd(1, 0, 8'd100, 4'h0, 32'h0);
        tick();
        idle_all();
        chk("l1_b1_vld", {31'd0, b1.readdatavalid}, 32'd1);
        chk("l1_b1_data", b1.readdata, 32'hCAFEF00D);
        chk("l1_b2_vld", {31'd0, b2.readdatavalid}, 32'd1);
        chk("l1_b2_oor", b2.readdata, 32'h0);
        tick();
        chk("l1_b1_pulse", {31'd0, b1.readdatavalid}, 32'd0);
        chk("l1_b1_hold", b1.readdata, 32'hCAFEF00D);

        // byte-enable merge
        a1_cmd(0, 1, 8'd5, 4'hF, 32'hAABBCCDD);
        tick();
        a1_cmd(0, 1, 8'd5, 4'h5, 32'h11223344);
        tick();
        a1_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        rd_a2_chk(8'd5, 32'hAA22CC44, "be_merge");
        tick();
        chk("be_pulse", {31'd0, a2.readdatavalid}, 32'd0);
        chk("be_hold", a2.readdata, 32'hAA22CC44);

        // same-port read-after-write
        a1_cmd(0, 1, 8'd20, 4'hF, 32'h12345678);
        tick();
        rd_a1_chk(8'd20, 32'h12345678, "raw_same");

        // write collision: s1 wins, s2 stalls one cycle then lands last
        a1_cmd(0, 1, 8'd10, 4'hF, 32'h1);
        a2_cmd(0, 1, 8'd10, 4'hF, 32'h2);
        #1;
        chk("col_a2_wait", {31'd0, a2.waitrequest}, 32'd1);
        chk("col_a1_wait", {31'd0, a1.waitrequest}, 32'd0);
        tick();
        a1_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        #1;
        chk("col_retry_wait", {31'd0, a2.waitrequest}, 32'd0);
        tick();
        a2_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        rd_a1_chk(8'd10, 32'h2, "col_final");

        // distinct addresses and same out-of-range address: no stall
        a1_cmd(0, 1, 8'd11, 4'hF, 32'h11);
        a2_cmd(0, 1, 8'd12, 4'hF, 32'h12);
        #1;
        chk("nocol_wait", {31'd0, a2.waitrequest}, 32'd0);
        tick();
        a1_cmd(0, 1, 8'd70, 4'hF, 32'h70);
        a2_cmd(0, 1, 8'd70, 4'hF, 32'h71);
        #1;
        chk("oor_nocol_wait", {31'd0, a2.waitrequest}, 32'd0);
        tick();
        idle_all();
        rd_a2_chk(8'd11, 32'h11, "nocol_a11");
        rd_a1_chk(8'd12, 32'h12, "nocol_a12");

        // mixed-port read during write returns old data
        a1_cmd(0, 1, 8'd7, 4'hF, 32'h5A5A5A5A);
        tick();
        a1_cmd(0, 1, 8'd7, 4'hF, 32'hFFFFFFFF);
        a2_cmd(1, 0, 8'd7, 4'h0, 32'h0);
        tick();
        idle_all();
        tick();
        chk("rdw_vld", {31'd0, a2.readdatavalid}, 32'd1);
        chk("rdw_old", a2.readdata, 32'h5A5A5A5A);
        rd_a2_chk(8'd7, 32'hFFFFFFFF, "rdw_new");

        // throughput: both ports read every cycle
        for (int i = 0; i < 8; i++) begin
            a1_cmd(0, 1, 8'(i), 4'hF, 32'h100 + i);
            tick();
        end
        idle_all();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                a1_cmd(1, 0, 8'(k), 4'h0, 32'h0);
                a2_cmd(1, 0, 8'(7 - k), 4'h0, 32'h0);
            end else begin
                idle_all();
            end
            tick();
            if (k >= 1 && k <= 8) begin
                chk($sformatf("tput_a1_vld_%0d", k), {31'd0, a1.readdatavalid}, 32'd1);
                chk($sformatf("tput_a1_dat_%0d", k), a1.readdata, 32'h100 + k - 1);
                chk($sformatf("tput_a2_dat_%0d", k), a2.readdata, 32'h108 - k);
            end else begin
                chk($sformatf("tput_a1_idle_%0d", k), {31'd0, a1.readdatavalid}, 32'd0);
            end
        end

        // out-of-range write discarded (would alias to word 0), read returns zero
        a1_cmd(0, 1, 8'd64, 4'hF, 32'hDEAD);
        tick();
        a1_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        rd_a2_chk(8'd64, 32'h0, "oor_rd64");
        rd_a1_chk(8'd0, 32'h100, "oor_alias0");
        rd_a1_chk(8'd6, 32'h106, "oor_alias6");
        rd_a2_chk(8'd200, 32'h0, "oor_rd200");

        // clken low for 3 cycles mid-read: valid shifts by 3, blocked write does nothing
        a1_cmd(1, 0, 8'd3, 4'h0, 32'h0);
        tick();
        a1_cmd(0, 1, 8'd3, 4'hF, 32'h00000BAD);
        clken = 1'b0;
        #1;
        chk("clk_a1_wait", {31'd0, a1.waitrequest}, 32'd1);
        chk("clk_a2_wait", {31'd0, a2.waitrequest}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("clk_frozen_%0d", c), {31'd0, a1.readdatavalid}, 32'd0);
        end
        a1_cmd(0, 0, 8'd0, 4'h0, 32'h0);
        clken = 1'b1;
        tick();
        chk("clk_late_vld", {31'd0, a1.readdatavalid}, 32'd1);
        chk("clk_late_data", a1.readdata, 32'h103);
        tick();
        chk("clk_late_pulse", {31'd0, a1.readdatavalid}, 32'd0);
        rd_a1_chk(8'd3, 32'h103, "clk_nowrite");

        // reset with two reads in flight
        a1_cmd(1, 0, 8'd1, 4'h0, 32'h0);
        a2_cmd(1, 0, 8'd2, 4'h0, 32'h0);
        tick();
        idle_all();
        reset = 1'b1;
        #1;
        chk("mrst_a1_wait", {31'd0, a1.waitrequest}, 32'd1);
        chk("mrst_a2_wait", {31'd0, a2.waitrequest}, 32'd1);
        chk("mrst_a1_data", a1.readdata, 32'h0);
        chk("mrst_a2_data", a2.readdata, 32'h0);
        tick();
        chk("mrst_a1_vld", {31'd0, a1.readdatavalid}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mrst_post_a1_%0d", c), {31'd0, a1.readdatavalid}, 32'd0);
            chk($sformatf("mrst_post_a2_%0d", c), {31'd0, a2.readdatavalid}, 32'd0);
        end
        rd_a1_chk(8'd1, 32'h101, "mrst_keep1");
        rd_a2_chk(8'd2, 32'h102, "mrst_keep2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/onchip_memory_dp.md
# onchip_memory_dp

Parametrised dual-port on-chip RAM exposing two Avalon-MM slaves (s1, s2) on one clock, successor to the single-port 32-bit on-chip memory. Adds configurable width/depth, selectable read latency with explicit `readdatavalid`, write-collision arbitration with `waitrequest` back-pressure, and out-of-range address protection. Sits on the Nios II system interconnect as program/data memory or as a CPU/DMA shared buffer.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 16: word-address width.
- `DEPTH`, 51200: number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- `READ_LATENCY`, 1: 1 or 2 cycles from read acceptance to data (2 adds an output register).
- `INIT_FILE`, "onchip_memory_dp.hex": initial contents, loaded at configuration/elaboration only.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high.
- `clken` in 1: global clock enable; low freezes the block.
- `s1_address` / `s2_address` in ADDR_WIDTH: word address.
- `s1_chipselect` / `s2_chipselect` in 1: slave select.
- `s1_read` / `s2_read` in 1: read request.
- `s1_write` / `s2_write` in 1: write request.
- `s1_byteenable` / `s2_byteenable` in DATA_WIDTH/8: byte lanes for writes.
- `s1_writedata` / `s2_writedata` in DATA_WIDTH: write data.
- `s1_readdata` / `s2_readdata` out DATA_WIDTH: read data, valid only with readdatavalid.
- `s1_readdatavalid` / `s2_readdatavalid` out 1: read data strobe.
- `s1_waitrequest` / `s2_waitrequest` out 1: command not accepted this cycle.

## Operation
- Command on port p accepted when `chipselect & (read|write) & ~waitrequest`. read and write asserted together: write only; no readdatavalid is produced.
- Write: each byte lane i with byteenable[i]=1 updated at the accepting edge; other lanes unchanged. byteenable = 0: no change.
- Read: returns the word at address; each accepted read yields exactly one readdatavalid pulse, in order.
- Out-of-range (address >= DEPTH): write discarded; read completes normally and returns all zeros.
- Same-port read-after-write: a read accepted the cycle after a write sees the new data.
- Mixed-port read-during-write (s1 writes A, s2 reads A in the same cycle, or vice versa): reader gets OLD data.
- Write collision (both ports write the same in-range address in the same cycle): s1 wins; `s2_waitrequest` high for that cycle, s2 write accepted next cycle if still presented (s2 ends up last writer). Different addresses or reads on both ports: no stall.
- s1_waitrequest = reset | ~clken. s2_waitrequest = reset | ~clken | collision (combinational from inputs).
- clken low: no accepts, memory unchanged, read pipeline and readdatavalid/readdata hold their values.
- Memory array is never cleared by reset; contents survive reset.

## Timing
- Reset values: s1/s2_readdata = 0, s1/s2_readdatavalid = 0; both waitrequest = 1 while reset is high.
- Reset mid-read: in-flight reads are discarded; no readdatavalid after reset deassertion for reads accepted before it.
- READ_LATENCY=1: read accepted at edge N -> readdatavalid/readdata high during cycle N+1 (one cycle only).
- READ_LATENCY=2: accepted at N -> valid during N+2. Back-to-back reads every cycle are sustained at full throughput on both ports.
- readdatavalid is a single-cycle pulse per read; readdata holds its last value when readdatavalid is low.
- Collision stall costs s2 exactly one cycle per colliding write.

## Test plan
- Reset: assert reset during two outstanding reads -> readdatavalid stays 0, readdata = 0, both waitrequest = 1 until release.
- Byte-enable write: s1 writes 0xAABBCCDD to addr 5 with be=0xF, then 0x11223344 with be=0x5 -> s2 read of addr 5 returns 0xAA22CC44 after READ_LATENCY cycles.
- Collision: s1 writes 0x1 and s2 writes 0x2 to addr 10 in the same cycle -> s2_waitrequest high one cycle, s2 retry accepted, final read of addr 10 = 0x2.
- Mixed read-during-write: addr 7 holds 0x5A5A5A5A; s1 writes 0xFFFFFFFF while s2 reads addr 7 -> s2 gets 0x5A5A5A5A; next s2 read -> 0xFFFFFFFF.
- Latency/throughput: READ_LATENCY=2, s1 reads addrs 0..7 on consecutive cycles -> eight consecutive readdatavalid pulses starting 2 cycles after the first accept, data in order.
- Out-of-range/clken: write 0xDEAD to addr DEPTH then read it -> 0; drop clken for 3 cycles mid-read -> waitrequest high, readdatavalid timing shifts by exactly 3 cycles, data unchanged.
